// File: rtl/disposition_queue_pkg.sv
// Shared types and defaults for the buffered disposition path: opcode encoding,
// the default disposition value and queue sizing helpers.
package Disposition_pkg;

   localparam int dispositionSize      = 16;
   localparam int DISP_Q_DEPTH_DEFAULT = 8;
   localparam int DISP_Q_CNT_W_DEFAULT = 16;

   typedef enum logic {
      no_opp = 1'b0,
      Disp   = 1'b1
   } disposition_operation_t;

   typedef logic [dispositionSize-1:0] disposition_t;

   localparam disposition_t DISPOSITION_DEFAULT = 16'hA5A5;

   function automatic disposition_t disposition_o();
      return DISPOSITION_DEFAULT;
   endfunction

   // Occupancy counter width for a queue of the given depth (must hold 0..depth).
   function automatic int disp_q_count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/disp_ring_buffer.sv
// In-order ring buffer: register storage, wrapping pointers and an occupancy
// count that alone decides full/empty. Flush clears pointers and count.
module disp_ring_buffer #(
   parameter int PAYLOAD_W = 16,
   parameter int DEPTH     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [PAYLOAD_W-1:0]       wr_data_i,
   output logic [PAYLOAD_W-1:0]       rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 do_push, do_pop;

   assign do_push = push_i && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule

// File: rtl/disposition_queue.sv
// Buffered disposition queue: filters or substitutes no-ops at the input,
// gates acceptance on occupancy, and keeps a saturating dropped-no-op count.
module disposition_queue
   import Disposition_pkg::*;
#(
   parameter int PAYLOAD_W = dispositionSize,
   parameter int DEPTH     = DISP_Q_DEPTH_DEFAULT,
   parameter int DROP_NOP  = 1,
   parameter int CNT_W     = DISP_Q_CNT_W_DEFAULT
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                flush,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  disposition_operation_t              in_opcode,
   input  logic [PAYLOAD_W-1:0]                in_args,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [PAYLOAD_W-1:0]                out_args,
   output logic [disp_q_count_w(DEPTH)-1:0]    count,
   output logic [CNT_W-1:0]                    nop_dropped
);
   localparam int Q_CNT_W = disp_q_count_w(DEPTH);

   logic                 is_nop, drop, full, accept, store, pop;
   logic [PAYLOAD_W-1:0] wr_data;
   logic [CNT_W-1:0]     nop_cnt_q, nop_cnt_d;

   assign is_nop   = (in_opcode == no_opp);
   assign drop     = (DROP_NOP != 0) && is_nop;
   assign full     = (count == Q_CNT_W'(DEPTH));
   // Dropped no-ops need no slot, so they are accepted even when full.
   assign in_ready = !flush && (!full || drop);
   assign accept   = in_valid && in_ready;
   assign store    = accept && !drop;
   assign wr_data  = is_nop ? PAYLOAD_W'(disposition_o()) : in_args;

   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready && !flush;

   disp_ring_buffer #(
      .PAYLOAD_W(PAYLOAD_W),
      .DEPTH    (DEPTH)
   ) u_ring (
      .clk      (clk),
      .reset    (reset),
      .flush_i  (flush),
      .push_i   (store),
      .pop_i    (pop),
      .wr_data_i(wr_data),
      .rd_data_o(out_args),
      .count_o  (count)
   );

   always_comb begin
      nop_cnt_d = nop_cnt_q;
      if (accept && drop && (nop_cnt_q != '1)) nop_cnt_d = nop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) nop_cnt_q <= '0;
      else       nop_cnt_q <= nop_cnt_d;
   end

   assign nop_dropped = nop_cnt_q;

endmodule

// File: tb/tb_disposition_queue.sv
// Bench for disposition_queue: two instances (no-op drop with 4-bit counter, and
// no-op substitution) share stimulus and are checked every cycle against queue models.
module tb_disposition_queue;
   import Disposition_pkg::*;

   localparam int W = 16;
   localparam int D = 8;
   localparam logic [W-1:0] DEF = 16'hA5A5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset, flush, in_valid, out_ready;
   disposition_operation_t in_opcode;
   logic [W-1:0]           in_args;

   logic         rdy_a, vld_a, rdy_b, vld_b;
   logic [W-1:0] args_a, args_b;
   logic [3:0]   cnt_a, cnt_b;
   logic [3:0]   nd_a;
   logic [15:0]  nd_b;

   disposition_queue #(.PAYLOAD_W(W), .DEPTH(D), .DROP_NOP(1), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
      .in_opcode(in_opcode), .in_args(in_args), .out_valid(vld_a), .out_ready(out_ready),
      .out_args(args_a), .count(cnt_a), .nop_dropped(nd_a));

   disposition_queue #(.PAYLOAD_W(W), .DEPTH(D), .DROP_NOP(0), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
      .in_opcode(in_opcode), .in_args(in_args), .out_valid(vld_b), .out_ready(out_ready),
      .out_args(args_b), .count(cnt_b), .nop_dropped(nd_b));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queues of stored payloads plus a drop tally.
   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   int           nda = 0;
   bit           started = 0;
   bit           acc_a, acc_b;

   always @(posedge clk) begin
      if (reset) begin
         qa.delete();
         qb.delete();
         nda = 0;
         started = 1;
      end else if (flush) begin
         qa.delete();
         qb.delete();
      end else begin
         acc_a = in_valid && (qa.size() < D || in_opcode == no_opp);
         acc_b = in_valid && (qb.size() < D);
         if (out_ready && qa.size() != 0) void'(qa.pop_front());
         if (out_ready && qb.size() != 0) void'(qb.pop_front());
         if (acc_a) begin
            if (in_opcode == Disp) qa.push_back(in_args);
            else if (nda < 15) nda++;
         end
         if (acc_b) qb.push_back((in_opcode == Disp) ? in_args : DEF);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("a_in_ready", 32'(rdy_a), 32'(!flush && (qa.size() < D || in_opcode == no_opp)));
         chk("a_out_valid", 32'(vld_a), 32'(qa.size() != 0));
         chk("a_count", 32'(cnt_a), qa.size());
         chk("a_nop_dropped", 32'(nd_a), nda);
         if (qa.size() != 0) chk("a_out_args", 32'(args_a), 32'(qa[0]));
         chk("b_in_ready", 32'(rdy_b), 32'(!flush && qb.size() < D));
         chk("b_out_valid", 32'(vld_b), 32'(qb.size() != 0));
         chk("b_count", 32'(cnt_b), qb.size());
         chk("b_nop_dropped", 32'(nd_b), 0);
         if (qb.size() != 0) chk("b_out_args", 32'(args_b), 32'(qb[0]));
      end
   end

   task automatic cyc(input logic v, input disposition_operation_t op, input logic [W-1:0] a,
                      input logic ordy, input logic fl = 1'b0, input logic rst = 1'b0);
      in_valid  = v;
      in_opcode = op;
      in_args   = a;
      out_ready = ordy;
      flush     = fl;
      reset     = rst;
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = 0; in_opcode = Disp; in_args = '0; out_ready = 0; flush = 0; reset = 1;
      cyc(0, Disp, 16'h0, 0, 0, 1);
      cyc(0, Disp, 16'h0, 0, 0, 1);
      chk("lit_reset_count", 32'(cnt_a), 0);
      chk("lit_reset_valid", 32'(vld_a), 0);
      chk("lit_reset_ready", 32'(rdy_a), 1);
      chk("lit_reset_nop", 32'(nd_a), 0);

      cyc(1, Disp, 16'h11, 0);
      cyc(1, Disp, 16'h22, 0);
      cyc(1, Disp, 16'h33, 0);
      chk("lit_abc_count", 32'(cnt_a), 3);
      chk("lit_abc_head", 32'(args_a), 32'h11);
      cyc(0, Disp, 16'h0, 1);
      chk("lit_drain_b", 32'(args_a), 32'h22);
      cyc(0, Disp, 16'h0, 1);
      chk("lit_drain_c", 32'(args_a), 32'h33);
      cyc(0, Disp, 16'h0, 1);
      chk("lit_drain_empty", 32'(vld_a), 0);

      for (int i = 0; i < D; i++) cyc(1, Disp, W'(16'h100 + i), 0);
      chk("lit_full_ready", 32'(rdy_a), 0);
      cyc(1, Disp, 16'h1FF, 0);
      chk("lit_full_reject", 32'(cnt_a), 8);
      cyc(1, Disp, 16'h1FE, 1);
      chk("lit_pop_frees", 32'(cnt_a), 7);
      chk("lit_ready_after_pop", 32'(rdy_a), 1);
      cyc(1, Disp, 16'h1FD, 1);
      chk("lit_push_pop_count", 32'(cnt_a), 7);
      cyc(1, Disp, 16'h1FC, 0);
      cyc(1, no_opp, 16'h0, 0);
      chk("lit_nop_when_full", 32'(nd_a), 1);
      chk("lit_full_head", 32'(args_a), 32'h102);

      for (int i = 0; i < 4; i++) cyc(0, Disp, 16'h0, 1);
      chk("lit_four_left", 32'(cnt_a), 4);
      cyc(1, Disp, 16'h777, 0, 1);
      chk("lit_flush_count", 32'(cnt_a), 0);
      chk("lit_flush_valid", 32'(vld_a), 0);
      chk("lit_flush_nop", 32'(nd_a), 1);

      cyc(1, Disp, 16'h5, 0);
      cyc(1, no_opp, 16'hFF, 0);
      cyc(1, Disp, 16'h6, 0);
      chk("lit_sub_count_b", 32'(cnt_b), 3);
      chk("lit_sub_count_a", 32'(cnt_a), 2);
      chk("lit_sub_head", 32'(args_b), 32'h5);
      cyc(0, Disp, 16'h0, 1);
      chk("lit_sub_default", 32'(args_b), 32'(DEF));
      cyc(0, Disp, 16'h0, 1);
      chk("lit_sub_last", 32'(args_b), 32'h6);
      cyc(0, Disp, 16'h0, 1);
      chk("lit_sub_empty", 32'(vld_b), 0);

      for (int i = 0; i < 19; i++) cyc(1, no_opp, W'($urandom), 0);
      chk("lit_nop_saturate", 32'(nd_a), 32'hF);
      cyc(1, Disp, 16'h42, 1);
      cyc(1, Disp, 16'h43, 0, 0, 1);
      chk("lit_midreset_count", 32'(cnt_a), 0);
      chk("lit_midreset_nop", 32'(nd_a), 0);
      chk("lit_midreset_count_b", 32'(cnt_b), 0);

      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) != 0,
             disposition_operation_t'($urandom_range(0, 3) != 0),
             W'($urandom),
             (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
             $urandom_range(0, 49) == 0,
             $urandom_range(0, 299) == 0);
      end
      cyc(0, Disp, 16'h0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
